// File: rtl/split_dist_pkg.sv
// rtl/split_dist_pkg.sv - shared types and constants for the split_dist stream distributor
//
// Purpose : FSM state encoding and lane count used by split_dist.
package split_dist_pkg;

  typedef enum logic [1:0] {
    FILL0 = 2'd0,
    FILL1 = 2'd1,
    FILL2 = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int NUM_LANES = 3;

endpackage

// File: rtl/split_lane_reg.sv
// rtl/split_lane_reg.sv - one lane register of the split_dist distributor
//
// Purpose : WIDTH-bit register with synchronous active-high reset to 0 and load enable.
// Ports   : clk   - clock
//           rst   - synchronous active-high reset
//           i_ld  - load enable
//           i_d   - data to load
//           o_q   - registered lane value
module split_lane_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_ld,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_ld) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/split_dist.sv
// rtl/split_dist.sv - round-robin distributor of one word stream into a registered triple
//
// Purpose : Consecutive accepted words fill lanes 0,1,2; the full triple is then
//           offered under out_valid/out_ready. No combinational path from in_data
//           to any output.
// Ports   : clk, rst            - clock, synchronous active-high reset
//           in_valid/in_ready   - input word handshake (in_ready from state, out_ready, rst)
//           in_data             - input word
//           out_valid/out_ready - triple handshake
//           out1/out2/out3      - lanes 0/1/2 of the triple (registered)
//           out_sum             - out1 + out2, WIDTH+1 bits (only with SPLIT_DIST_SUM_EN)
// Options : define SPLIT_DIST_SUM_EN to add the registered out_sum output.
module split_dist
  import split_dist_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3
`ifdef SPLIT_DIST_SUM_EN
  ,
  output logic [WIDTH:0]   out_sum
`endif
);

  state_t               r_state;
  logic                 r_out_valid;
  logic                 w_accept;
  logic                 w_release;
  logic [NUM_LANES-1:0] w_lane_ld;
  logic [WIDTH-1:0]     w_lane_q [NUM_LANES];

  // In HOLD a new word can only enter when the triple leaves on the same edge,
  // since that word overwrites lane 0.
  assign in_ready  = !rst && ((r_state != HOLD) || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_release = r_out_valid && out_ready;

  always_comb begin
    w_lane_ld = '0;
    case (r_state)
      FILL0, HOLD: w_lane_ld[0] = w_accept;
      FILL1:       w_lane_ld[1] = w_accept;
      FILL2:       w_lane_ld[2] = w_accept;
      default:     w_lane_ld    = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= FILL0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        FILL0: if (w_accept) r_state <= FILL1;
        FILL1: if (w_accept) r_state <= FILL2;
        FILL2: begin
          if (w_accept) begin
            r_state     <= HOLD;
            r_out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (w_release) begin
            r_out_valid <= 1'b0;
            r_state     <= w_accept ? FILL1 : FILL0;
          end
        end
        default: r_state <= FILL0;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    split_lane_reg #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .i_ld (w_lane_ld[g]),
      .i_d  (in_data),
      .o_q  (w_lane_q[g])
    );
  end

  assign out_valid = r_out_valid;
  assign out1      = w_lane_q[0];
  assign out2      = w_lane_q[1];
  assign out3      = w_lane_q[2];

`ifdef SPLIT_DIST_SUM_EN
  logic [WIDTH:0] r_sum;

  // Computed on the lane-2 load, when lanes 0 and 1 already hold the triple,
  // so the sum appears on the same edge as out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum <= '0;
    end else if (w_lane_ld[2]) begin
      r_sum <= {1'b0, w_lane_q[0]} + {1'b0, w_lane_q[1]};
    end
  end

  assign out_sum = r_sum;
`endif

endmodule

// File: doc/split_dist.md
Name: split_dist

Overview:
- Inverse of the three-input merge stage: takes one stream of WIDTH-bit words and distributes consecutive words round-robin into three lane registers.
- Once all three lanes hold a word, the triple is presented together under a valid/ready handshake.
- Sits downstream of a single taint-source input and feeds three independent consumer paths, so each lane output can be annotated as its own sink.
- Purely synchronous; no combinational path from in_data to any out*.

Parameters:
- WIDTH, 8, bit width of in_data and of each lane output.

Ports:
- clk  input  1  single clock, all state updates on posedge clk
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  in_data carries a word this cycle
- in_data  input  WIDTH  word to distribute
- in_ready  output  1  block accepts in_data this cycle (combinational from state, out_ready, rst)
- out_valid  output  1  out1/out2/out3 hold a complete triple (registered)
- out_ready  input  1  consumer takes the triple this cycle
- out1  output  WIDTH  lane 0: first word of triple (registered)
- out2  output  WIDTH  lane 1: second word (registered)
- out3  output  WIDTH  lane 2: third word (registered)

Behaviour:
- Clocking/reset: one clock. Reset is synchronous and active-high. Clock port is clk, reset port is rst.
- On a clk edge with rst=1:
  - state <= FILL0.
  - out_valid, out1, out2, out3 <= 0.
  - Any partially filled triple is discarded.
- While rst=1, in_ready=0.
- Accept: a word is accepted when in_valid && in_ready. Release: the triple is released when out_valid && out_ready.
- FSM states (2-bit):
  - FILL0: in_ready=1. On accept: out1<=in_data, go to FILL1.
  - FILL1: in_ready=1. On accept: out2<=in_data, go to FILL2.
  - FILL2: in_ready=1. On accept: out3<=in_data, out_valid<=1, go to HOLD.
  - HOLD: in_ready=out_ready.
    - Release with no accept: out_valid<=0, go to FILL0.
    - Release and accept in the same cycle: out1<=in_data, out_valid<=0, go to FILL1.
    - No release: all outputs stay stable.
- No accept: the state and all lane registers hold.
- Lanes are written only on the accept that targets them. Stale lane values persist and are visible, but they are meaningful only while out_valid=1.
- Latency: the third word accepted at edge t gives out_valid=1 from edge t onward, i.e. one cycle after it is presented.
- Throughput: at most one triple per 3 cycles with a continuous in_valid and out_ready held high.
- Backpressure: in HOLD with out_ready=0, in_ready=0 and the upstream word is not consumed.
- out_valid must not drop without a release; out1..out3 must not change while out_valid=1.
- Reset during HOLD or a FILL state: return to FILL0 next edge; the triple is lost, no partial output.
- in_valid is ignored (no accept) when in_ready=0.

Optional Feature:
- Macro: SPLIT_DIST_SUM_EN.
- Defined:
  - Adds output out_sum (WIDTH+1 bits) = out1 + out2, zero-extended, no wrap.
  - out_sum is registered in the same edge that sets out_valid, so it is aligned with the triple.
  - out_sum is reset to 0 and held stable during HOLD.
  - Used to exercise recombination of split lanes.
- Undefined: the port and adder are absent; all other behaviour is identical.

Decomposition:
- Package split_dist_pkg:
  - state typedef enum logic [1:0] {FILL0, FILL1, FILL2, HOLD}.
  - localparam NUM_LANES = 3.
- Sub-module split_lane_reg:
  - WIDTH-bit register with synchronous active-high reset to 0 and load enable.
  - Instantiated three times for out1..out3.
- The FSM, in_ready logic and out_valid stay in the top level.

Test Plan:
- Reset then stream 0x11, 0x22, 0x33 on consecutive cycles, out_ready=1:
  - out_valid=1 for exactly one cycle with out1=0x11, out2=0x22, out3=0x33.
  - in_ready stays 1 throughout.
- Fill with 0xA0, 0xA1, 0xA2, hold out_ready=0 for 5 cycles while in_valid=1 with 0xFF:
  - in_ready=0 and the triple is stable for all 5 cycles.
  - Raising out_ready releases the triple and accepts 0xFF into out1 on the same edge, state FILL1.
- Continuous stream 0x01..0x09, out_ready=1:
  - Three triples (01,02,03), (04,05,06), (07,08,09) are released.
  - No word is dropped or duplicated; out_valid is high 1 of every 3 cycles.
- Accept 0x55, 0x66, then assert rst for one cycle, then send 0x77, 0x88, 0x99:
  - All outputs are 0 after the reset edge.
  - The released triple is (77,88,99); 0x55/0x66 never appear with out_valid=1.
- Gaps: in_valid toggles 1,0,1,0,1 with 0x10, 0x20, 0x30:
  - The triple forms only on the third accept; state holds across idle cycles.
- With SPLIT_DIST_SUM_EN defined, triple (0xFF, 0xFF, 0x00):
  - out_sum=0x1FE, aligned with out_valid.
  - Without the macro, the design elaborates with no out_sum port.
